// File: rtl/frame_fetch_ctrl_if.sv
// ROM read port and display-FIFO write port of the frame fetch controller.
// master = controller side, slave = ROM/FIFO side.
interface frame_fetch_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_wr;
    logic              full_fifo;

    modport master (
        output rom_addr, rom_en, fifo_wdata, fifo_wr,
        input  rom_data, full_fifo
    );

    modport slave (
        input  rom_addr, rom_en, fifo_wdata, fifo_wr,
        output rom_data, full_fifo
    );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// Streams one frame of ROM words into the display FIFO through a credit-managed skid buffer.
// Optional `define AUTO_RESTART_EN: frames repeat back-to-back without start.
module frame_fetch_ctrl #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 13,
    parameter int FRAME_WORDS = 4800,
    parameter int ROM_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    frame_fetch_ctrl_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                start_err
);
    localparam int SKID_DEPTH = ROM_LAT + 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W      = $clog2(SKID_DEPTH);
    localparam int OUT_W      = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic              fifo_wr;
    logic              push;
    logic              last_issue;
    logic [ROM_LAT-1:0] valid_pipe;
    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  skid_cnt;
    logic [OUT_W-1:0]  inflight, outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push           = valid_pipe[ROM_LAT-1];
    assign last_issue     = rom_en && (rom_addr == ADDR_W'(FRAME_WORDS - 1));
    assign bus.rom_addr   = rom_addr;
    assign bus.rom_en     = rom_en;
    assign bus.fifo_wr    = fifo_wr;
    assign bus.fifo_wdata = skid_mem[rd_ptr];

    // Credits: every issued read owns a skid slot until it is written out.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LAT; i++)
            inflight = inflight + OUT_W'(valid_pipe[i]);
        fifo_wr     = (skid_cnt != '0) && !bus.full_fifo;
        outstanding = inflight + OUT_W'(skid_cnt) - OUT_W'(fifo_wr);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
`ifdef AUTO_RESTART_EN
            IDLE:  state_nxt = FETCH;
`else
            IDLE:  if (start) state_nxt = FETCH;
`endif
            FETCH: if (last_issue) state_nxt = DRAIN;
            DRAIN: if (outstanding == '0) state_nxt = DONE;
`ifdef AUTO_RESTART_EN
            DONE:  state_nxt = FETCH;
`else
            DONE:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rom_en     = (state == FETCH) && (outstanding < OUT_W'(SKID_DEPTH));
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            valid_pipe <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_cnt   <= '0;
            start_err  <= 1'b0;
        end else begin
            // Cleared in DONE as well so an automatic restart begins at address 0.
            if (state == IDLE || state == DONE) rom_addr <= '0;
            else if (rom_en)                    rom_addr <= rom_addr + ADDR_W'(1);
            valid_pipe[0] <= rom_en;
            for (int unsigned i = 1; i < ROM_LAT; i++)
                valid_pipe[i] <= valid_pipe[i-1];
            if (push)    wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_wr) rd_ptr <= ptr_inc(rd_ptr);
            skid_cnt <= skid_cnt + CNT_W'(push) - CNT_W'(fifo_wr);
`ifdef AUTO_RESTART_EN
            start_err <= 1'b0;
`else
            start_err <= start && (state != IDLE);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) skid_mem[wr_ptr] <= bus.rom_data;
    end

    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !fifo_wr && (skid_cnt == CNT_W'(SKID_DEPTH))));
endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Directed + randomized bench for frame_fetch_ctrl; the model tracks issued/written word counts.
module tb_frame_fetch_ctrl;
    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 13;
    localparam int FW      = 4800;
    localparam int ROM_LAT = 1;
    localparam int SKID    = ROM_LAT + 2;
    localparam logic [23:0] ROM_K = 24'h3C0000;

    logic clk = 1'b0;
    logic rst, start;
    logic busy, frame_done, start_err;

    frame_fetch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    frame_fetch_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_WORDS(FW), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] word_of(input int a);
        return 24'(a) + ROM_K;
    endfunction

    // ROM with one clock of read latency.
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= word_of(int'(bus.rom_addr));

    int vectors = 0, miscompares = 0;
    int issued = 0, written = 0, done_cnt = 0, err_cnt = 0;
    bit prev_wr = 0, tog = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Words must leave in address order, never while full, and issue must respect credits.
    task automatic sample();
        int out;
        out = issued - written - ((bus.fifo_wr === 1'b1) ? 1 : 0);
        if (bus.full_fifo) chk("wr_while_full", 32'(bus.fifo_wr), 0);
        if (bus.fifo_wr === 1'b1) begin
            chk("wdata", 32'(bus.fifo_wdata), 32'(word_of(written % FW)));
            written++;
        end
        if (bus.rom_en === 1'b1) begin
            chk("rom_addr", 32'(bus.rom_addr), 32'(issued % FW));
            chk("credit", 32'(out < SKID), 1);
            issued++;
        end
        if (frame_done === 1'b1) begin
            chk("done_timing", 32'(prev_wr && (written % FW == 0) && written > 0), 1);
            done_cnt++;
        end
        if (start_err === 1'b1) err_cnt++;
        prev_wr = (bus.fifo_wr === 1'b1);
    endtask

    task automatic step(input logic f, input logic s, input logic r);
        @(posedge clk);
        #1;
        bus.full_fifo = f;
        start = s;
        rst = r;
        #1;
        sample();
    endtask

    function automatic logic pick(input int mode);
        tog = ~tog;
        case (mode)
            1:       return tog;
            2:       return ($urandom_range(0, 3) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic new_frame();
        issued = 0;
        written = 0;
        prev_wr = 0;
    endtask

    task automatic run_to(input int target, input int mode);
        int c = 0;
        while (written < target && c < 40000) begin
            step(pick(mode), 1'b0, 1'b0);
            c++;
        end
        chk("run_to_budget", 32'(c < 40000), 1);
    endtask

    task automatic finish_frame(input int mode);
        int base = done_cnt;
        int c = 0;
        while (done_cnt == base && c < 40000) begin
            step(pick(mode), 1'b0, 1'b0);
            c++;
        end
        chk("frame_done_seen", 32'(done_cnt - base), 1);
        chk("frame_words", 32'(written), FW);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        bus.full_fifo = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        new_frame();
        done_cnt = 0;
        err_cnt = 0;
        step(0, 0, 0);
        chk("rst_rom_en", 32'(bus.rom_en), 0);
        chk("rst_fifo_wr", 32'(bus.fifo_wr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_start_err", 32'(start_err), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);

`ifdef AUTO_RESTART_EN
        begin
            int c = 0;
            while (done_cnt < 3 && c < 60000) begin
                step(pick(2), ($urandom_range(0, 15) == 0), 1'b0);
                c++;
            end
            chk("auto_frames", 32'(done_cnt), 3);
            chk("auto_words", 32'(written), 3 * FW);
            chk("auto_no_start_err", 32'(err_cnt), 0);
        end
`else
        // Latency and full-rate stream.
        step(0, 1, 0);
        chk("t1_e0_no_wr", 32'(bus.fifo_wr), 0);
        step(0, 0, 0);
        chk("t1_issue", 32'(bus.rom_en), 1);
        chk("t1_lat1", 32'(bus.fifo_wr), 0);
        step(0, 0, 0);
        chk("t1_lat2", 32'(bus.fifo_wr), 0);
        step(0, 0, 0);
        chk("t1_first_wr", 32'(bus.fifo_wr), 1);
        for (int i = 1; i < FW; i++) begin
            step(0, 0, 0);
            chk("t1_stream", 32'(bus.fifo_wr), 1);
        end
        step(0, 0, 0);
        chk("t1_done", 32'(frame_done), 1);
        chk("t1_busy_in_done", 32'(busy), 1);
        chk("t1_count", 32'(written), FW);
        step(0, 0, 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_done_pulse", 32'(frame_done), 0);

        // 50-cycle stall mid-frame.
        new_frame();
        step(0, 1, 0);
        run_to(2000, 0);
        for (int i = 0; i < 50; i++) step(1, 0, 0);
        chk("t2_stall_no_issue", 32'(bus.rom_en), 0);
        chk("t2_stall_credits", 32'(issued - written), SKID);
        step(0, 0, 0);
        chk("t2_resume", 32'(bus.fifo_wr), 1);
        finish_frame(0);
        step(0, 0, 0);

        // full_fifo toggling every cycle.
        new_frame();
        base = done_cnt;
        step(0, 1, 0);
        finish_frame(1);
        repeat (3) step(0, 0, 0);
        chk("t3_one_done", 32'(done_cnt - base), 1);

        // start while busy.
        new_frame();
        base = err_cnt;
        step(0, 1, 0);
        run_to(1000, 2);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("t4_start_err", 32'(start_err), 1);
        finish_frame(2);
        repeat (20) step(0, 0, 0);
        chk("t4_err_once", 32'(err_cnt - base), 1);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_no_second_frame", 32'(issued), FW);

        // reset with reads in flight.
        new_frame();
        step(0, 1, 0);
        run_to(2500, 2);
        step(0, 0, 1);
        new_frame();
        step(0, 0, 0);
        chk("t5_rom_en", 32'(bus.rom_en), 0);
        chk("t5_fifo_wr", 32'(bus.fifo_wr), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_frame_done", 32'(frame_done), 0);
        chk("t5_start_err", 32'(start_err), 0);
        chk("t5_rom_addr", 32'(bus.rom_addr), 0);
        step(0, 1, 0);
        finish_frame(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
